// File: rtl/mem_port_arbiter_if.sv
// Bundles the CPU port, DMA port and memory-array side of the unified memory arbiter.
// The slave modport is the arbiter itself; master is whatever drives requests and the array.
interface mem_port_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          cpu_req;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic          cpu_gnt;
    logic          cpu_rvalid;
    logic [DW-1:0] cpu_rdata;

    logic          dma_req;
    logic          dma_we;
    logic [AW-1:0] dma_addr;
    logic [DW-1:0] dma_wdata;
    logic          dma_gnt;
    logic          dma_rvalid;
    logic [DW-1:0] dma_rdata;

    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    logic          busy;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_gnt, cpu_rvalid, cpu_rdata,
        input  dma_req, dma_we, dma_addr, dma_wdata,
        output dma_gnt, dma_rvalid, dma_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata,
        output busy
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_gnt, cpu_rvalid, cpu_rdata,
        output dma_req, dma_we, dma_addr, dma_wdata,
        input  dma_gnt, dma_rvalid, dma_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata,
        input  busy
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one unified memory between the CPU and a DMA/debug loader.
// Writes complete in the issue cycle; reads hold the memory for RD_LAT wait cycles.
module mem_port_arbiter #(
    parameter int AW     = 32,
    parameter int DW     = 32,
    parameter int RD_LAT = 2
) (
    input  logic              clk,
    input  logic              reset,
    mem_port_arbiter_if.slave bus
);

    if (RD_LAT < 1 || RD_LAT > 8) begin : g_bad_rd_lat
        $error("mem_port_arbiter: RD_LAT must be in 1..8");
    end

    localparam int CW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

    typedef enum logic {IDLE, WAIT} state_t;
    typedef enum logic {OWN_CPU, OWN_DMA} owner_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    owner_t        last_owner_q, last_owner_d;
    owner_t        owner_q, owner_d;

    logic          cpu_wins;
    logic          win_we;
    logic [AW-1:0] win_addr;
    logic [DW-1:0] win_wdata;

    // last_owner resets to DMA so that the CPU wins the very first tie
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            last_owner_q <= OWN_DMA;
            owner_q      <= OWN_CPU;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            last_owner_q <= last_owner_d;
            owner_q      <= owner_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        last_owner_d   = last_owner_q;
        owner_d        = owner_q;
        bus.cpu_gnt    = 1'b0;
        bus.cpu_rvalid = 1'b0;
        bus.cpu_rdata  = '0;
        bus.dma_gnt    = 1'b0;
        bus.dma_rvalid = 1'b0;
        bus.dma_rdata  = '0;
        bus.mem_en     = 1'b0;
        bus.mem_we     = 1'b0;
        bus.mem_addr   = '0;
        bus.mem_wdata  = '0;
        bus.busy       = (state_q != IDLE);

        cpu_wins  = bus.cpu_req && (!bus.dma_req || last_owner_q == OWN_DMA);
        win_we    = cpu_wins ? bus.cpu_we    : bus.dma_we;
        win_addr  = cpu_wins ? bus.cpu_addr  : bus.dma_addr;
        win_wdata = cpu_wins ? bus.cpu_wdata : bus.dma_wdata;

        case (state_q)
            IDLE: begin
                // Issue is suppressed while reset is held so every strobe stays low
                if (!reset && (bus.cpu_req || bus.dma_req)) begin
                    bus.mem_en    = 1'b1;
                    bus.mem_we    = win_we;
                    bus.mem_addr  = win_addr;
                    bus.mem_wdata = win_wdata;
                    bus.cpu_gnt   = cpu_wins;
                    bus.dma_gnt   = !cpu_wins;
                    owner_d       = cpu_wins ? OWN_CPU : OWN_DMA;
                    last_owner_d  = owner_d;
                    if (!win_we) begin
                        state_d = WAIT;
                        cnt_d   = CW'(RD_LAT - 1);
                    end
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    if (owner_q == OWN_CPU) begin
                        bus.cpu_rvalid = 1'b1;
                        bus.cpu_rdata  = bus.mem_rdata;
                    end else begin
                        bus.dma_rvalid = 1'b1;
                        bus.dma_rdata  = bus.mem_rdata;
                    end
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: three instances (RD_LAT 2, 1, 8) share one stimulus
// set, and sel routes requests to a single instance while the others sit idle.
module tb_mem_port_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_req, cpu_we, dma_req, dma_we;
    logic [31:0] cpu_addr, cpu_wdata, dma_addr, dma_wdata;
    logic [1:0]  sel;
    int          cur_lat;
    int          tests_run;
    int          tests_failed;

    logic [2:0]  cpu_gnt_v, cpu_rvalid_v, dma_gnt_v, dma_rvalid_v, mem_en_v, mem_we_v, busy_v;
    logic [31:0] cpu_rdata_a [3];
    logic [31:0] dma_rdata_a [3];
    logic [31:0] mem_addr_a  [3];
    logic [31:0] mem_wdata_a [3];

    logic        cpu_gnt, cpu_rvalid, dma_gnt, dma_rvalid, mem_en, mem_we, busy;
    logic [31:0] cpu_rdata, dma_rdata, mem_addr, mem_wdata;

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_model(input logic [31:0] a);
        if (a == 32'h10) return 32'hE3A00001;
        return {a[15:0], ~a[15:0]};
    endfunction

    for (genvar g = 0; g < 3; g++) begin : g_inst
        localparam int LAT = (g == 0) ? 2 : (g == 1) ? 1 : 8;

        mem_port_arbiter_if #(.AW(AW), .DW(DW)) bus ();
        logic [31:0] rd_addr = '0;
        int          age = 0;

        assign bus.cpu_req   = (sel == 2'(g)) && cpu_req;
        assign bus.cpu_we    = cpu_we;
        assign bus.cpu_addr  = cpu_addr;
        assign bus.cpu_wdata = cpu_wdata;
        assign bus.dma_req   = (sel == 2'(g)) && dma_req;
        assign bus.dma_we    = dma_we;
        assign bus.dma_addr  = dma_addr;
        assign bus.dma_wdata = dma_wdata;

        mem_port_arbiter #(.AW(AW), .DW(DW), .RD_LAT(LAT)) dut (
            .clk   (clk),
            .reset (reset),
            .bus   (bus)
        );

        // Array model: read data is driven only in the exact cycle T+LAT, garbage otherwise
        always @(posedge clk) begin
            if (bus.mem_en && !bus.mem_we) begin
                age     <= 1;
                rd_addr <= bus.mem_addr;
            end else if (age != 0 && age < 16) begin
                age <= age + 1;
            end
        end
        assign bus.mem_rdata = (age == LAT) ? mem_model(rd_addr) : 32'hBAD0BAD0;

        assign cpu_gnt_v[g]    = bus.cpu_gnt;
        assign cpu_rvalid_v[g] = bus.cpu_rvalid;
        assign dma_gnt_v[g]    = bus.dma_gnt;
        assign dma_rvalid_v[g] = bus.dma_rvalid;
        assign mem_en_v[g]     = bus.mem_en;
        assign mem_we_v[g]     = bus.mem_we;
        assign busy_v[g]       = bus.busy;
        assign cpu_rdata_a[g]  = bus.cpu_rdata;
        assign dma_rdata_a[g]  = bus.dma_rdata;
        assign mem_addr_a[g]   = bus.mem_addr;
        assign mem_wdata_a[g]  = bus.mem_wdata;
    end

    assign cpu_gnt    = cpu_gnt_v[sel];
    assign cpu_rvalid = cpu_rvalid_v[sel];
    assign dma_gnt    = dma_gnt_v[sel];
    assign dma_rvalid = dma_rvalid_v[sel];
    assign mem_en     = mem_en_v[sel];
    assign mem_we     = mem_we_v[sel];
    assign busy       = busy_v[sel];
    assign cpu_rdata  = cpu_rdata_a[sel];
    assign dma_rdata  = dma_rdata_a[sel];
    assign mem_addr   = mem_addr_a[sel];
    assign mem_wdata  = mem_wdata_a[sel];

    task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s (RD_LAT=%0d): got %h expected %h", tag, cur_lat, got, exp);
        end
    endtask

    task automatic apply_stimulus(input logic creq, input logic cwe, input logic [31:0] caddr,
                                  input logic [31:0] cwdata, input logic dreq, input logic dwe,
                                  input logic [31:0] daddr, input logic [31:0] dwdata);
        cpu_req   = creq;
        cpu_we    = cwe;
        cpu_addr  = caddr;
        cpu_wdata = cwdata;
        dma_req   = dreq;
        dma_we    = dwe;
        dma_addr  = daddr;
        dma_wdata = dwdata;
    endtask

    task automatic next_cycle;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic check_all_quiet(input string tag);
        check_output({tag, " cpu_gnt"}, cpu_gnt, 0);
        check_output({tag, " dma_gnt"}, dma_gnt, 0);
        check_output({tag, " cpu_rvalid"}, cpu_rvalid, 0);
        check_output({tag, " dma_rvalid"}, dma_rvalid, 0);
        check_output({tag, " cpu_rdata"}, cpu_rdata, 0);
        check_output({tag, " dma_rdata"}, dma_rdata, 0);
        check_output({tag, " mem_en"}, mem_en, 0);
        check_output({tag, " mem_we"}, mem_we, 0);
        check_output({tag, " mem_addr"}, mem_addr, 0);
        check_output({tag, " mem_wdata"}, mem_wdata, 0);
        check_output({tag, " busy"}, busy, 0);
    endtask

    task automatic run_single_read;
        do_reset();
        apply_stimulus(1, 0, 32'h10, 0, 0, 0, 0, 0);
        @(negedge clk);
        check_output("s1 cpu_gnt", cpu_gnt, 1);
        check_output("s1 mem_en", mem_en, 1);
        check_output("s1 mem_we", mem_we, 0);
        check_output("s1 mem_addr", mem_addr, 32'h10);
        check_output("s1 busy at T", busy, 0);
        check_output("s1 dma_gnt", dma_gnt, 0);
        next_cycle();
        apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0);
        for (int k = 1; k <= cur_lat; k++) begin
            @(negedge clk);
            check_output($sformatf("s1 cpu_rvalid T+%0d", k), cpu_rvalid, k == cur_lat);
            check_output($sformatf("s1 cpu_rdata T+%0d", k), cpu_rdata,
                         (k == cur_lat) ? 32'hE3A00001 : 32'h0);
            check_output($sformatf("s1 busy T+%0d", k), busy, 1);
            check_output($sformatf("s1 mem_en T+%0d", k), mem_en, 0);
            check_output($sformatf("s1 dma_rvalid T+%0d", k), dma_rvalid, 0);
            check_output($sformatf("s1 dma_rdata T+%0d", k), dma_rdata, 0);
            next_cycle();
        end
        @(negedge clk);
        check_all_quiet("s1 after read");
        next_cycle();
    endtask

    task automatic run_tie_reads;
        logic [6:0] exp_cg   = 7'b0000001;
        logic [6:0] exp_dg   = 7'b0001000;
        logic [6:0] exp_cv   = 7'b0000100;
        logic [6:0] exp_dv   = 7'b0100000;
        logic [6:0] exp_busy = 7'b0110110;
        logic       cg, dg;
        do_reset();
        apply_stimulus(1, 0, 32'h10, 0, 1, 0, 32'h20, 0);
        for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            check_output($sformatf("s2 cpu_gnt c%0d", c), cpu_gnt, exp_cg[c]);
            check_output($sformatf("s2 dma_gnt c%0d", c), dma_gnt, exp_dg[c]);
            check_output($sformatf("s2 cpu_rvalid c%0d", c), cpu_rvalid, exp_cv[c]);
            check_output($sformatf("s2 dma_rvalid c%0d", c), dma_rvalid, exp_dv[c]);
            check_output($sformatf("s2 cpu_rdata c%0d", c), cpu_rdata,
                         exp_cv[c] ? 32'hE3A00001 : 32'h0);
            check_output($sformatf("s2 dma_rdata c%0d", c), dma_rdata,
                         exp_dv[c] ? mem_model(32'h20) : 32'h0);
            check_output($sformatf("s2 busy c%0d", c), busy, exp_busy[c]);
            cg = cpu_gnt;
            dg = dma_gnt;
            next_cycle();
            if (cg) cpu_req = 1'b0;
            if (dg) dma_req = 1'b0;
        end
    endtask

    task automatic run_dma_write;
        do_reset();
        apply_stimulus(0, 0, 0, 0, 1, 1, 32'h40, 32'hDEADBEEF);
        @(negedge clk);
        check_output("s3 mem_en", mem_en, 1);
        check_output("s3 mem_we", mem_we, 1);
        check_output("s3 mem_addr", mem_addr, 32'h40);
        check_output("s3 mem_wdata", mem_wdata, 32'hDEADBEEF);
        check_output("s3 dma_gnt", dma_gnt, 1);
        check_output("s3 cpu_gnt", cpu_gnt, 0);
        check_output("s3 busy", busy, 0);
        next_cycle();
        apply_stimulus(1, 0, 32'h44, 0, 0, 0, 0, 0);
        @(negedge clk);
        check_output("s3 cpu_gnt T+1", cpu_gnt, 1);
        check_output("s3 mem_addr T+1", mem_addr, 32'h44);
        check_output("s3 mem_we T+1", mem_we, 0);
        check_output("s3 mem_wdata T+1", mem_wdata, 0);
        check_output("s3 dma_rvalid T+1", dma_rvalid, 0);
        next_cycle();
        apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0);
        for (int k = 1; k <= 2; k++) begin
            @(negedge clk);
            check_output($sformatf("s3 dma_rvalid k%0d", k), dma_rvalid, 0);
            check_output($sformatf("s3 cpu_rvalid k%0d", k), cpu_rvalid, k == 2);
            check_output($sformatf("s3 cpu_rdata k%0d", k), cpu_rdata,
                         (k == 2) ? mem_model(32'h44) : 32'h0);
            next_cycle();
        end
    endtask

    task automatic run_reset_mid_read;
        do_reset();
        apply_stimulus(1, 0, 32'h10, 0, 0, 0, 0, 0);
        @(negedge clk);
        check_output("s4 cpu_gnt", cpu_gnt, 1);
        next_cycle();
        apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0);
        reset = 1'b1;
        #1;
        check_all_quiet("s4 in reset");
        for (int c = 0; c < 3; c++) begin
            if (c == 2) apply_stimulus(1, 0, 32'h10, 0, 1, 0, 32'h20, 0);
            @(negedge clk);
            check_all_quiet($sformatf("s4 reset c%0d", c));
            next_cycle();
        end
        reset = 1'b0;
        @(negedge clk);
        check_output("s4 pair cpu_gnt", cpu_gnt, 1);
        check_output("s4 pair dma_gnt", dma_gnt, 0);
        next_cycle();
        cpu_req = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            check_output($sformatf("s4 pair cpu_rvalid c%0d", c), cpu_rvalid, c == 2);
            check_output($sformatf("s4 pair dma_gnt c%0d", c), dma_gnt, c == 3);
            next_cycle();
        end
        apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (3) next_cycle();
    endtask

    task automatic run_fairness;
        int p;
        int slot;
        int ph;
        int gnt_cnt;
        int rv_cnt;
        int exp_cnt;
        p       = cur_lat + 1;
        gnt_cnt = 0;
        rv_cnt  = 0;
        exp_cnt = (cur_lat == 2) ? 10 : (cur_lat == 1) ? 15 : 4;
        do_reset();
        apply_stimulus(1, 0, 32'h100, 0, 1, 0, 32'h200, 0);
        for (int c = 0; c < 30; c++) begin
            slot = c / p;
            ph   = c % p;
            @(negedge clk);
            check_output($sformatf("s5 cpu_gnt c%0d", c), cpu_gnt, ph == 0 && slot % 2 == 0);
            check_output($sformatf("s5 dma_gnt c%0d", c), dma_gnt, ph == 0 && slot % 2 == 1);
            check_output($sformatf("s5 cpu_rvalid c%0d", c), cpu_rvalid,
                         ph == cur_lat && slot % 2 == 0);
            check_output($sformatf("s5 dma_rvalid c%0d", c), dma_rvalid,
                         ph == cur_lat && slot % 2 == 1);
            check_output($sformatf("s5 cpu_rdata c%0d", c), cpu_rdata,
                         (ph == cur_lat && slot % 2 == 0) ? mem_model(32'h100) : 32'h0);
            check_output($sformatf("s5 dma_rdata c%0d", c), dma_rdata,
                         (ph == cur_lat && slot % 2 == 1) ? mem_model(32'h200) : 32'h0);
            gnt_cnt += int'(cpu_gnt) + int'(dma_gnt);
            rv_cnt  += int'(cpu_rvalid) + int'(dma_rvalid);
            next_cycle();
        end
        apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0);
        for (int c = 0; c <= cur_lat; c++) begin
            @(negedge clk);
            check_output($sformatf("s5 drain cpu_gnt c%0d", c), cpu_gnt, 0);
            check_output($sformatf("s5 drain dma_gnt c%0d", c), dma_gnt, 0);
            rv_cnt += int'(cpu_rvalid) + int'(dma_rvalid);
            next_cycle();
        end
        check_output("s5 gnt count", gnt_cnt, exp_cnt);
        check_output("s5 rvalid count", rv_cnt, exp_cnt);
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        sel          = 2'd0;
        cur_lat      = 2;
        apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0);
        reset = 1'b1;
        #2;
        check_all_quiet("reset state");

        run_single_read();
        run_tie_reads();
        run_dma_write();
        run_reset_mid_read();
        run_fairness();

        sel     = 2'd1;
        cur_lat = 1;
        run_single_read();
        run_fairness();

        sel     = 2'd2;
        cur_lat = 8;
        run_single_read();
        run_fairness();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
